// File: rtl/debug_pkg.sv
// Shared definitions for the debug I/O bridge.
//   cap_state_e : capture FSM state, also driven out on cap_state.
//   rb_words    : number of OUT_W-wide readback words covering the snapshot.
//   rb_evcnt    : readback select that returns the event counter.
//   rb_status   : readback select that returns {vmask, cap_state, ptr}.
//   ptr_width   : width of the auto-increment slice pointer.
package debug_pkg;

  typedef enum logic [1:0] {
    LIVE   = 2'd0,
    ARMED  = 2'd1,
    FROZEN = 2'd2
  } cap_state_e;

  function automatic int rb_words(input int num_ch, input int data_w, input int out_w);
    return (num_ch * data_w) / out_w;
  endfunction

  function automatic int rb_evcnt(input int num_ch, input int data_w, input int out_w);
    return rb_words(num_ch, data_w, out_w);
  endfunction

  function automatic int rb_status(input int num_ch, input int data_w, input int out_w);
    return rb_words(num_ch, data_w, out_w) + 1;
  endfunction

  function automatic int ptr_width(input int num_slices);
    return (num_slices > 1) ? $clog2(num_slices) : 1;
  endfunction

endpackage

// File: rtl/dbg_stim_loader.sv
// Stimulus loader: assembles a wide stimulus vector from narrow pin slices
// and commits it to the core in one cycle.
//   clk, reset  : core clock, synchronous active-high reset
//   sel         : slice index for manual writes
//   din         : slice data
//   load_en     : write din into staging this cycle
//   auto_inc    : 1 = write at ptr and advance it, 0 = write at sel
//   set         : copy staging to stim_out
//   stim_out    : committed stimulus
//   stim_valid  : high the cycle after each commit
//   ptr         : auto-increment slice pointer (exposed for status readback)
module dbg_stim_loader
  import debug_pkg::*;
#(
  parameter int IN_W   = 10,
  parameter int STIM_W = 160,
  parameter int SEL_W  = 4,
  parameter int PTR_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [SEL_W-1:0]  sel,
  input  logic [IN_W-1:0]   din,
  input  logic              load_en,
  input  logic              auto_inc,
  input  logic              set,
  output logic [STIM_W-1:0] stim_out,
  output logic              stim_valid,
  output logic [PTR_W-1:0]  ptr
);

  localparam int NS = STIM_W / IN_W;

  logic [STIM_W-1:0] staging;
  int                wr_idx;
  logic              wr_ok;

  // Manual writes beyond the last slice are dropped; the pointer never leaves range.
  always_comb begin
    wr_idx = auto_inc ? int'(ptr) : int'(sel);
    wr_ok  = load_en && (wr_idx < NS);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      staging    <= '0;
      stim_out   <= '0;
      stim_valid <= 1'b0;
      ptr        <= '0;
    end else begin
      stim_valid <= set;
      // NOTE: non-blocking assignment makes a commit in the same cycle as a
      // write see the staging value from before that write.
      if (set) stim_out <= staging;
      for (int s = 0; s < NS; s++) begin
        if (wr_ok && (wr_idx == s)) staging[s*IN_W +: IN_W] <= din;
      end
      if (load_en && auto_inc) ptr <= (ptr == PTR_W'(NS - 1)) ? '0 : ptr + 1'b1;
    end
  end

endmodule

// File: rtl/debug_io_bridge.sv
// Board-level debug harness between FPGA pins and the core pipeline.
// Loads stimulus through dbg_stim_loader, captures NUM_CH writeback channels
// in LIVE / ARMED / FROZEN mode, counts valid beats and reads captured state
// back through a narrow registered port.
//   clk, reset   : core clock, synchronous active-high reset
//   sel          : slice select (manual load) and word select (readback)
//   din/load_en/auto_inc/set : stimulus loading and commit
//   arm          : enter ARMED
//   release_req  : return to LIVE ("release" is a reserved word)
//   trig_mask    : channels allowed to trigger a freeze
//   obs_valid/obs_data : observed channels, channel c at [c*DATA_W +: DATA_W]
//   stim_out/stim_valid : committed stimulus and its one-cycle strobe
//   dout         : readback of the word selected on the previous cycle
//   cap_state    : current capture state
module debug_io_bridge
  import debug_pkg::*;
#(
  parameter int IN_W   = 10,
  parameter int STIM_W = 160,
  parameter int NUM_CH = 4,
  parameter int DATA_W = 32,
  parameter int OUT_W  = 16,
  parameter int CNT_W  = 16,
  parameter int SEL_W  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [SEL_W-1:0]         sel,
  input  logic [IN_W-1:0]          din,
  input  logic                     load_en,
  input  logic                     auto_inc,
  input  logic                     set,
  input  logic                     arm,
  input  logic                     release_req,
  input  logic [NUM_CH-1:0]        trig_mask,
  input  logic [NUM_CH-1:0]        obs_valid,
  input  logic [NUM_CH*DATA_W-1:0] obs_data,
  output logic [STIM_W-1:0]        stim_out,
  output logic                     stim_valid,
  output logic [OUT_W-1:0]         dout,
  output logic [1:0]               cap_state
);

  localparam int NS        = STIM_W / IN_W;
  localparam int PTR_W     = ptr_width(NS);
  localparam int RW        = rb_words(NUM_CH, DATA_W, OUT_W);
  localparam int RB_EVCNT  = rb_evcnt(NUM_CH, DATA_W, OUT_W);
  localparam int RB_STATUS = rb_status(NUM_CH, DATA_W, OUT_W);
  localparam int STAT_W    = NUM_CH + 2 + PTR_W;

  cap_state_e                state, state_nxt;
  logic [NUM_CH*DATA_W-1:0]  snapshot;
  logic [NUM_CH-1:0]         vmask;
  logic [CNT_W-1:0]          evcnt;
  logic [PTR_W-1:0]          ptr;
  logic [NUM_CH-1:0]         cap_en;
  logic                      vmask_clr;
  logic                      vmask_load;
  logic                      trig_hit;
  logic [OUT_W-1:0]          dout_d;

  dbg_stim_loader #(
    .IN_W   (IN_W),
    .STIM_W (STIM_W),
    .SEL_W  (SEL_W),
    .PTR_W  (PTR_W)
  ) u_loader (
    .clk        (clk),
    .reset      (reset),
    .sel        (sel),
    .din        (din),
    .load_en    (load_en),
    .auto_inc   (auto_inc),
    .set        (set),
    .stim_out   (stim_out),
    .stim_valid (stim_valid),
    .ptr        (ptr)
  );

  assign trig_hit  = |(obs_valid & trig_mask);
  assign cap_state = state;

  // Release wins over arm and trigger. A trigger freezes every valid channel,
  // not only the masked ones that caused it.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    state_nxt  = state;
    cap_en     = '0;
    vmask_clr  = 1'b0;
    vmask_load = 1'b0;
    if (release_req) begin
      state_nxt = LIVE;
      if (state == LIVE) cap_en = obs_valid;
    end else begin
      unique case (state)
        LIVE: begin
          if (arm) begin
            state_nxt = ARMED;
            vmask_clr = 1'b1;
          end else begin
            cap_en = obs_valid;
          end
        end
        ARMED: begin
          if (trig_hit) begin
            state_nxt  = FROZEN;
            cap_en     = obs_valid;
            vmask_load = 1'b1;
          end
        end
        FROZEN: begin
          if (arm) begin
            state_nxt = ARMED;
            vmask_clr = 1'b1;
          end
        end
        default: state_nxt = LIVE;
      endcase
    end
  end

  // Readback mux; registered below so dout follows sel by one cycle.
  always_comb begin
    dout_d = '0;
    for (int w = 0; w < RW; w++) begin
      if (int'(sel) == w) dout_d = snapshot[w*OUT_W +: OUT_W];
    end
    if (int'(sel) == RB_EVCNT)  dout_d[CNT_W-1:0]  = evcnt;
    if (int'(sel) == RB_STATUS) dout_d[STAT_W-1:0] = {vmask, state, ptr};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= LIVE;
      snapshot <= '0;
      vmask    <= '0;
      evcnt    <= '0;
      dout     <= '0;
    end else begin
      state <= state_nxt;
      dout  <= dout_d;
      for (int c = 0; c < NUM_CH; c++) begin
        if (cap_en[c]) snapshot[c*DATA_W +: DATA_W] <= obs_data[c*DATA_W +: DATA_W];
      end
      if (vmask_clr)       vmask <= '0;
      else if (vmask_load) vmask <= obs_valid;
      else                 vmask <= vmask | cap_en;
      if (|obs_valid && (evcnt != '1)) evcnt <= evcnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_debug_io_bridge.sv
module tb_debug_io_bridge;

  localparam int IN_W   = 10;
  localparam int STIM_W = 160;
  localparam int NUM_CH = 4;
  localparam int DATA_W = 32;
  localparam int OUT_W  = 16;
  localparam int CNT_W  = 16;
  localparam int SEL_W  = 4;
  localparam int NS     = STIM_W / IN_W;
  localparam int RW     = NUM_CH * DATA_W / OUT_W;
  localparam int PTR_W  = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [SEL_W-1:0]         sel;
  logic [IN_W-1:0]          din;
  logic                     load_en, auto_inc, set, arm, rel;
  logic [NUM_CH-1:0]        trig_mask, obs_valid;
  logic [NUM_CH*DATA_W-1:0] obs_data;
  logic [STIM_W-1:0]        stim_out;
  logic                     stim_valid;
  logic [OUT_W-1:0]         dout;
  logic [1:0]               cap_state;

  int checks = 0;
  int errors = 0;

  // Reference model: slices, per-channel words and plain integers.
  logic [IN_W-1:0]   stg_m  [NS];
  logic [IN_W-1:0]   stim_m [NS];
  logic [DATA_W-1:0] snap_m [NUM_CH];
  int                ptr_m, state_m, evcnt_m;
  logic [NUM_CH-1:0] vmask_m;
  logic              valid_m;
  logic [OUT_W-1:0]  dout_m;

  debug_io_bridge dut (
    .clk         (clk),
    .reset       (reset),
    .sel         (sel),
    .din         (din),
    .load_en     (load_en),
    .auto_inc    (auto_inc),
    .set         (set),
    .arm         (arm),
    .release_req (rel),
    .trig_mask   (trig_mask),
    .obs_valid   (obs_valid),
    .obs_data    (obs_data),
    .stim_out    (stim_out),
    .stim_valid  (stim_valid),
    .dout        (dout),
    .cap_state   (cap_state)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] chan(input int c);
    return obs_data[c*DATA_W +: DATA_W];
  endfunction

  function automatic logic [OUT_W-1:0] snap_word(input int w);
    logic [DATA_W-1:0] v;
    v = snap_m[w / 2];
    return (w % 2 == 0) ? v[15:0] : v[31:16];
  endfunction

  function automatic logic [STIM_W-1:0] exp_stim();
    logic [STIM_W-1:0] v;
    for (int k = 0; k < NS; k++) v[k*IN_W +: IN_W] = stim_m[k];
    return v;
  endfunction

  function automatic logic [OUT_W-1:0] exp_status();
    int s;
    s = int'(vmask_m) * (1 << (PTR_W + 2)) + state_m * (1 << PTR_W) + ptr_m;
    return OUT_W'(s);
  endfunction

  task automatic idle();
    reset = 1'b0; sel = '0; din = '0; load_en = 1'b0; auto_inc = 1'b0;
    set = 1'b0; arm = 1'b0; rel = 1'b0; trig_mask = '0; obs_valid = '0; obs_data = '0;
  endtask

  // Advance the model by one clock using the inputs currently driven, then
  // let the DUT take the same edge and settle.
  task automatic step();
    if (reset) begin
      for (int k = 0; k < NS; k++) begin stg_m[k] = '0; stim_m[k] = '0; end
      for (int c = 0; c < NUM_CH; c++) snap_m[c] = '0;
      ptr_m = 0; state_m = 0; evcnt_m = 0; vmask_m = '0; valid_m = 1'b0; dout_m = '0;
    end else begin
      if (int'(sel) < RW)          dout_m = snap_word(int'(sel));
      else if (int'(sel) == RW)     dout_m = OUT_W'(evcnt_m);
      else if (int'(sel) == RW + 1) dout_m = exp_status();
      else                          dout_m = '0;
      valid_m = set;
      if (set) stim_m = stg_m;
      if (load_en) begin
        if (auto_inc) begin
          stg_m[ptr_m] = din;
          ptr_m = (ptr_m + 1) % NS;
        end else if (int'(sel) < NS) begin
          stg_m[int'(sel)] = din;
        end
      end
      if (rel || (state_m == 0 && !arm)) begin
        if (state_m == 0)
          for (int c = 0; c < NUM_CH; c++)
            if (obs_valid[c]) begin snap_m[c] = chan(c); vmask_m[c] = 1'b1; end
        state_m = 0;
      end else if (state_m == 1) begin
        if ((obs_valid & trig_mask) != 0) begin
          for (int c = 0; c < NUM_CH; c++) if (obs_valid[c]) snap_m[c] = chan(c);
          vmask_m = obs_valid;
          state_m = 2;
        end
      end else if (arm) begin
        vmask_m = '0;
        state_m = 1;
      end
      if (obs_valid != 0 && evcnt_m < CNT_MAX) evcnt_m++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic read_word(input int s);
    idle();
    sel = SEL_W'(s);
    step();
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1; load_en = 1'b1; set = 1'b1; arm = 1'b1; obs_valid = '1; din = 10'h2AA;
    step();
    step();
    idle();
    checks++;
    if (stim_out !== '0) begin errors++; $display("FAIL reset_stim got=%h want=0", stim_out); end
    checks++;
    if (stim_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", stim_valid); end
    checks++;
    if (dout !== '0) begin errors++; $display("FAIL reset_dout got=%h want=0", dout); end
    checks++;
    if (cap_state !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d want=0", cap_state); end
    read_word(RW + 1);
    checks++;
    if (dout !== 16'h0000) begin errors++; $display("FAIL reset_status got=%h want=0000", dout); end
  endtask

  task automatic test_auto_load();
    for (int k = 0; k < NS; k++) begin
      idle(); load_en = 1'b1; auto_inc = 1'b1; din = IN_W'(k);
      step();
    end
    idle(); set = 1'b1;
    step();
    checks++;
    if (stim_valid !== 1'b1) begin errors++; $display("FAIL auto_valid got=%b want=1", stim_valid); end
    for (int k = 0; k < NS; k++) begin
      checks++;
      if (stim_out[k*IN_W +: IN_W] !== IN_W'(k))
        begin errors++; $display("FAIL auto_slice%0d got=%h want=%h", k, stim_out[k*IN_W +: IN_W], k); end
    end
    idle();
    step();
    checks++;
    if (stim_valid !== 1'b0) begin errors++; $display("FAIL auto_valid_pulse got=%b want=0", stim_valid); end
    read_word(RW + 1);
    checks++;
    if (dout[PTR_W-1:0] !== '0) begin errors++; $display("FAIL auto_ptr_wrap got=%0d want=0", dout[PTR_W-1:0]); end
  endtask

  task automatic test_manual_load();
    idle(); load_en = 1'b1; sel = 4'd3; din = 10'h3FF;
    step();
    idle(); load_en = 1'b1; sel = 4'd15; din = 10'h155; set = 1'b1;
    step();
    checks++;
    if (stim_out[39:30] !== 10'h3FF) begin errors++; $display("FAIL man_slice3 got=%h want=3ff", stim_out[39:30]); end
    checks++;
    if (stim_out[159:150] !== 10'h00F) begin errors++; $display("FAIL man_slice15_old got=%h want=00f", stim_out[159:150]); end
    idle(); set = 1'b1;
    step();
    checks++;
    if (stim_out[159:150] !== 10'h155) begin errors++; $display("FAIL man_slice15_new got=%h want=155", stim_out[159:150]); end
    checks++;
    if (stim_out !== exp_stim()) begin errors++; $display("FAIL man_stim got=%h want=%h", stim_out, exp_stim()); end
  endtask

  task automatic test_live_readback();
    idle(); obs_valid = 4'b0100; obs_data[2*DATA_W +: DATA_W] = 32'hDEADBEEF;
    step();
    read_word(4);
    checks++;
    if (dout !== 16'hBEEF) begin errors++; $display("FAIL live_lo got=%h want=beef", dout); end
    read_word(5);
    checks++;
    if (dout !== 16'hDEAD) begin errors++; $display("FAIL live_hi got=%h want=dead", dout); end
  endtask

  task automatic test_arm_trigger();
    idle(); arm = 1'b1; trig_mask = 4'b0010;
    step();
    idle(); trig_mask = 4'b0010; obs_valid = 4'b0001; obs_data[31:0] = 32'h0BAD0BAD;
    step();
    checks++;
    if (cap_state !== 2'd1) begin errors++; $display("FAIL arm_untriggered got=%0d want=1", cap_state); end
    idle(); trig_mask = 4'b0010; obs_valid = 4'b1010;
    obs_data[1*DATA_W +: DATA_W] = 32'h11111111;
    obs_data[3*DATA_W +: DATA_W] = 32'h33333333;
    step();
    checks++;
    if (cap_state !== 2'd2) begin errors++; $display("FAIL arm_frozen got=%0d want=2", cap_state); end
    read_word(RW + 1);
    checks++;
    if (dout[9:6] !== 4'b1010) begin errors++; $display("FAIL arm_vmask got=%b want=1010", dout[9:6]); end
    idle(); obs_valid = 4'b0010; obs_data[1*DATA_W +: DATA_W] = 32'hAAAAAAAA;
    step();
    read_word(2);
    checks++;
    if (dout !== 16'h1111) begin errors++; $display("FAIL frozen_hold got=%h want=1111", dout); end
    read_word(7);
    checks++;
    if (dout !== 16'h3333) begin errors++; $display("FAIL frozen_ch3 got=%h want=3333", dout); end
  endtask

  task automatic test_release_priority();
    idle(); arm = 1'b1;
    step();
    idle(); rel = 1'b1; trig_mask = 4'b0010; obs_valid = 4'b0010;
    obs_data[1*DATA_W +: DATA_W] = 32'h55555555;
    step();
    checks++;
    if (cap_state !== 2'd0) begin errors++; $display("FAIL rel_vs_trig got=%0d want=0", cap_state); end
    read_word(2);
    checks++;
    if (dout !== 16'h1111) begin errors++; $display("FAIL rel_no_capture got=%h want=1111", dout); end
    idle(); arm = 1'b1;
    step();
    idle(); arm = 1'b1; rel = 1'b1;
    step();
    checks++;
    if (cap_state !== 2'd0) begin errors++; $display("FAIL rel_vs_arm got=%0d want=0", cap_state); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      idle();
      reset     = ($urandom_range(0, 63) == 0);
      sel       = SEL_W'($urandom);
      din       = IN_W'($urandom);
      load_en   = $urandom_range(0, 1) == 1;
      auto_inc  = $urandom_range(0, 1) == 1;
      set       = $urandom_range(0, 3) == 0;
      trig_mask = NUM_CH'($urandom);
      obs_valid = NUM_CH'($urandom);
      for (int c = 0; c < NUM_CH; c++) obs_data[c*DATA_W +: DATA_W] = $urandom;
      // arm and release are kept apart, and arm is not raised in ARMED.
      case ($urandom_range(0, 9))
        0: rel = 1'b1;
        1, 2: arm = (state_m != 1);
        default: ;
      endcase
      step();
      checks++;
      if (stim_out !== exp_stim()) begin errors++; $display("FAIL rnd_stim@%0d got=%h want=%h", i, stim_out, exp_stim()); end
      checks++;
      if (stim_valid !== valid_m) begin errors++; $display("FAIL rnd_valid@%0d got=%b want=%b", i, stim_valid, valid_m); end
      checks++;
      if (dout !== dout_m) begin errors++; $display("FAIL rnd_dout@%0d got=%h want=%h", i, dout, dout_m); end
      checks++;
      if (cap_state !== 2'(state_m)) begin errors++; $display("FAIL rnd_state@%0d got=%0d want=%0d", i, cap_state, state_m); end
    end
  endtask

  task automatic test_saturation();
    idle(); obs_valid = 4'b0001; obs_data[31:0] = 32'h12345678;
    for (int i = 0; i < 70000; i++) step();
    read_word(RW);
    checks++;
    if (dout !== 16'hFFFF) begin errors++; $display("FAIL sat_evcnt got=%h want=ffff", dout); end
    read_word(RW + 1);
    checks++;
    if (dout !== dout_m) begin errors++; $display("FAIL sat_status got=%h want=%h", dout, dout_m); end
    for (int s = RW + 2; s < (1 << SEL_W); s++) begin
      read_word(s);
      checks++;
      if (dout !== 16'h0000) begin errors++; $display("FAIL rb_unused%0d got=%h want=0000", s, dout); end
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_auto_load();
    test_manual_load();
    test_live_readback();
    test_arm_trigger();
    test_release_priority();
    test_random();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
